// File: rtl/rd53_afe_lbnl_fe_ctrl.sv
// Per-pixel front-end controller for the LBNL AFE: shadow/active config pair
// with atomic apply, and discriminator-to-ToT hit records over valid/ready.
module rd53_afe_lbnl_fe_ctrl #(
    parameter int TOT_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             enable,
    input  logic             cfg_wr,
    input  logic [9:0]       cfg_data,
    input  logic             cfg_apply,
    output logic             cfg_busy,
    output logic             afe_S0,
    output logic             afe_S1,
    output logic [3:0]       afe_DTH1,
    output logic [3:0]       afe_DTH2,
    input  logic             afe_outdis,
    output logic             hit_valid,
    output logic [TOT_W-1:0] hit_tot,
    input  logic             hit_ready,
    output logic [7:0]       drop_cnt
);

    localparam logic [TOT_W-1:0] TOT_MAX = '1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   disc, disc_q, rise;
    logic [TOT_W-1:0]       tot_q, tot_d;
    logic                   commit, buf_free;
    logic                   hit_valid_q, hit_valid_d;
    logic [TOT_W-1:0]       hit_tot_q, hit_tot_d;
    logic [7:0]             drop_q, drop_d;
    logic [9:0]             shadow_q, shadow_d;
    logic [9:0]             active_q, active_d;
    logic                   pend_q, pend_d;
    logic                   pend_eff, wr_ok, xfer;

    // Discriminator is active-low; idle level 1 keeps the chain inactive out of reset.
    assign disc = ~sync_q[SYNC_STAGES-1];
    assign rise = disc & ~disc_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sync_q <= '1;
            disc_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], afe_outdis};
            disc_q <= disc;
        end
    end

    always_comb begin
        state_d = state_q;
        tot_d   = tot_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && rise) begin
                    tot_d   = TOT_W'(1);
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!enable) begin
                    tot_d   = '0;
                    state_d = IDLE;
                end else if (disc) begin
                    if (tot_q != TOT_MAX) begin
                        tot_d = tot_q + TOT_W'(1);
                    end
                end else begin
                    commit  = 1'b1;
                    tot_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                tot_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // A pop and a push may share a cycle, so a ready consumer frees the slot.
    assign buf_free = ~hit_valid_q | hit_ready;

    always_comb begin
        hit_valid_d = hit_valid_q & ~hit_ready;
        hit_tot_d   = hit_tot_q;
        drop_d      = drop_q;
        if (commit) begin
            if (buf_free) begin
                hit_valid_d = 1'b1;
                hit_tot_d   = tot_q;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    // Transfer also fires in the commit/abort cycle so the new config lands on
    // the edge that returns the FSM to IDLE, never while a hit is in flight.
    always_comb begin
        wr_ok    = cfg_wr & ~pend_q;
        shadow_d = wr_ok ? cfg_data : shadow_q;
        pend_eff = pend_q | cfg_apply;
        xfer     = pend_eff & ((state_q == IDLE) || (state_d == IDLE));
        active_d = xfer ? shadow_d : active_q;
        pend_d   = pend_eff & ~xfer;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            tot_q       <= '0;
            hit_valid_q <= 1'b0;
            hit_tot_q   <= '0;
            drop_q      <= '0;
            shadow_q    <= '0;
            active_q    <= '0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tot_q       <= tot_d;
            hit_valid_q <= hit_valid_d;
            hit_tot_q   <= hit_tot_d;
            drop_q      <= drop_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
        end
    end

    assign cfg_busy  = pend_q;
    assign afe_S0    = active_q[9];
    assign afe_S1    = active_q[8];
    assign afe_DTH1  = active_q[7:4];
    assign afe_DTH2  = active_q[3:0];
    assign hit_valid = hit_valid_q;
    assign hit_tot   = hit_tot_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_rd53_afe_lbnl_fe_ctrl.sv
// Self-checking bench for rd53_afe_lbnl_fe_ctrl: randomized pulses compared
// against pulse-level expectations (ToT, latency, drops, config timing).
module tb_rd53_afe_lbnl_fe_ctrl;

    localparam int TOT_W   = 4;
    localparam int SYNC    = 2;
    localparam int TOT_MAX = (1 << TOT_W) - 1;

    logic             clk;
    logic             rst_b;
    logic             enable;
    logic             cfg_wr;
    logic [9:0]       cfg_data;
    logic             cfg_apply;
    logic             cfg_busy;
    logic             afe_S0;
    logic             afe_S1;
    logic [3:0]       afe_DTH1;
    logic [3:0]       afe_DTH2;
    logic             afe_outdis;
    logic             hit_valid;
    logic [TOT_W-1:0] hit_tot;
    logic             hit_ready;
    logic [7:0]       drop_cnt;

    int errors = 0;
    int checks = 0;
    int exp_drop = 0;
    logic [9:0] cfg_a = 10'b10_0101_1010;
    logic [9:0] cfg_b;
    logic [9:0] cfg_c;

    rd53_afe_lbnl_fe_ctrl #(.TOT_W(TOT_W), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_b(rst_b), .enable(enable),
        .cfg_wr(cfg_wr), .cfg_data(cfg_data), .cfg_apply(cfg_apply),
        .cfg_busy(cfg_busy), .afe_S0(afe_S0), .afe_S1(afe_S1),
        .afe_DTH1(afe_DTH1), .afe_DTH2(afe_DTH2), .afe_outdis(afe_outdis),
        .hit_valid(hit_valid), .hit_tot(hit_tot), .hit_ready(hit_ready),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse-level expectations derived directly from the ToT and latency rules.
    function automatic int exp_tot(input int n);
        return (n > TOT_MAX) ? TOT_MAX : n;
    endfunction

    function automatic int exp_latency(input int n);
        return SYNC + n + 1;
    endfunction

    function automatic int sat_drop(input int d);
        return (d > 255) ? 255 : d;
    endfunction

    function automatic logic [9:0] afe_word();
        return {afe_S0, afe_S1, afe_DTH1, afe_DTH2};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pad low for n edges; returns the edge count at which hit_valid is first seen.
    task automatic pulse_measure(input int n, output int lat, output int tot);
        lat = -1;
        tot = -1;
        afe_outdis = 1'b0;
        for (int e = 1; e <= n + 20; e++) begin
            tick();
            if (e == n) afe_outdis = 1'b1;
            if (hit_valid && lat < 0) begin
                lat = e;
                tot = int'(hit_tot);
                break;
            end
        end
        afe_outdis = 1'b1;
        tick();
    endtask

    task automatic drive_pulse(input int n, input int tail);
        afe_outdis = 1'b0;
        for (int e = 0; e < n; e++) tick();
        afe_outdis = 1'b1;
        for (int e = 0; e < tail; e++) tick();
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        enable = 1'b0; cfg_wr = 1'b0; cfg_data = '0; cfg_apply = 1'b0;
        afe_outdis = 1'b1; hit_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (afe_word() !== 10'd0 || cfg_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_cfg: afe=%b busy=%b required afe=0 busy=0", afe_word(), cfg_busy);
        end
        checks++;
        if (hit_valid !== 1'b0 || hit_tot !== '0 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_hit: valid=%b tot=%0d drop=%0d required 0/0/0", hit_valid, hit_tot, drop_cnt);
        end
        rst_b = 1'b1;
        repeat (2) tick();
        checks++;
        if (hit_valid !== 1'b0 || cfg_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: valid=%b busy=%b required 0/0", hit_valid, cfg_busy);
        end
        $display("reset: released, outputs checked");
    endtask

    task automatic test_cfg_idle();
        logic busy_seen;
        busy_seen = 1'b0;
        cfg_wr = 1'b1; cfg_data = cfg_a; cfg_apply = 1'b1;
        tick();
        cfg_wr = 1'b0; cfg_apply = 1'b0;
        busy_seen = busy_seen | cfg_busy;
        checks++;
        if (afe_S0 !== 1'b1 || afe_S1 !== 1'b0 || afe_DTH1 !== 4'd5 || afe_DTH2 !== 4'd10) begin
            errors++;
            $display("FAIL cfg_idle_apply: afe=%b required %b", afe_word(), cfg_a);
        end
        repeat (3) begin
            tick();
            busy_seen = busy_seen | cfg_busy;
        end
        checks++;
        if (busy_seen !== 1'b0) begin
            errors++;
            $display("FAIL cfg_idle_busy: busy_seen=%b required 0", busy_seen);
        end
        $display("cfg_idle: wrote+applied %b, afe=%b", cfg_a, afe_word());
    endtask

    task automatic test_single_hit();
        int lat, tot;
        enable = 1'b1; hit_ready = 1'b1;
        pulse_measure(6, lat, tot);
        checks++;
        if (lat != exp_latency(6) || tot != exp_tot(6)) begin
            errors++;
            $display("FAIL single_hit: lat=%0d tot=%0d required lat=%0d tot=%0d", lat, tot, exp_latency(6), exp_tot(6));
        end
        checks++;
        if (hit_valid !== 1'b0 || drop_cnt !== 8'(exp_drop)) begin
            errors++;
            $display("FAIL single_hit_pop: valid=%b drop=%0d required 0/%0d", hit_valid, drop_cnt, exp_drop);
        end
        $display("single_hit: n=6 lat=%0d tot=%0d", lat, tot);
    endtask

    task automatic test_saturate();
        int lat, tot;
        pulse_measure(40, lat, tot);
        checks++;
        if (tot != exp_tot(40) || lat != exp_latency(40)) begin
            errors++;
            $display("FAIL saturate: tot=%0d lat=%0d required tot=%0d lat=%0d", tot, lat, exp_tot(40), exp_latency(40));
        end
        $display("saturate: n=40 tot=%0d", tot);
    endtask

    task automatic test_random_pulses();
        int lat, tot, n;
        for (int k = 0; k < 10; k++) begin
            n = int'($urandom_range(1, 30));
            pulse_measure(n, lat, tot);
            repeat ($urandom_range(1, 4)) tick();
            checks++;
            if (lat != exp_latency(n) || tot != exp_tot(n)) begin
                errors++;
                $display("FAIL random_pulse[%0d]: n=%0d lat=%0d tot=%0d required lat=%0d tot=%0d",
                         k, n, lat, tot, exp_latency(n), exp_tot(n));
            end
            $display("random_pulse[%0d]: n=%0d lat=%0d tot=%0d", k, n, lat, tot);
        end
    endtask

    task automatic test_back_to_back();
        int n[3];
        hit_ready = 1'b0;
        for (int k = 0; k < 3; k++) n[k] = int'($urandom_range(1, 20));
        for (int k = 0; k < 3; k++) begin
            drive_pulse(n[k], 6);
            if (k > 0) exp_drop = sat_drop(exp_drop + 1);
            checks++;
            if (hit_valid !== 1'b1 || int'(hit_tot) != exp_tot(n[0]) || drop_cnt !== 8'(exp_drop)) begin
                errors++;
                $display("FAIL back_to_back[%0d]: valid=%b tot=%0d drop=%0d required 1/%0d/%0d",
                         k, hit_valid, hit_tot, drop_cnt, exp_tot(n[0]), exp_drop);
            end
            $display("back_to_back[%0d]: n=%0d held_tot=%0d drop=%0d", k, n[k], hit_tot, drop_cnt);
        end
        hit_ready = 1'b1;
        tick();
        checks++;
        if (hit_valid !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_pop: valid=%b required 0", hit_valid);
        end
    endtask

    task automatic test_apply_midpulse();
        logic done;
        cfg_b = 10'($urandom);
        if (cfg_b == cfg_a) cfg_b = ~cfg_a;
        cfg_c = ~cfg_b;
        cfg_wr = 1'b1; cfg_data = cfg_b;
        tick();
        cfg_wr = 1'b0;
        checks++;
        if (afe_word() !== cfg_a || cfg_busy !== 1'b0) begin
            errors++;
            $display("FAIL shadow_only: afe=%b busy=%b required %b/0", afe_word(), cfg_busy, cfg_a);
        end
        afe_outdis = 1'b0;
        repeat (4) tick();
        cfg_apply = 1'b1;
        tick();
        cfg_apply = 1'b0;
        cfg_wr = 1'b1; cfg_data = cfg_c;
        checks++;
        if (cfg_busy !== 1'b1 || afe_word() !== cfg_a) begin
            errors++;
            $display("FAIL apply_busy: busy=%b afe=%b required 1/%b", cfg_busy, afe_word(), cfg_a);
        end
        done = 1'b0;
        for (int e = 6; e <= 40; e++) begin
            tick();
            cfg_wr = 1'b0;
            if (e == 10) afe_outdis = 1'b1;
            checks++;
            if (hit_valid) begin
                done = 1'b1;
                if (cfg_busy !== 1'b0 || afe_word() !== cfg_b || int'(hit_tot) != exp_tot(10) || e != exp_latency(10)) begin
                    errors++;
                    $display("FAIL apply_commit: busy=%b afe=%b tot=%0d edge=%0d required 0/%b/%0d/%0d",
                             cfg_busy, afe_word(), hit_tot, e, cfg_b, exp_tot(10), exp_latency(10));
                end
                break;
            end else if (cfg_busy !== 1'b1 || afe_word() !== cfg_a) begin
                errors++;
                $display("FAIL apply_hold[%0d]: busy=%b afe=%b required 1/%b", e, cfg_busy, afe_word(), cfg_a);
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL apply_timeout: hit_valid=0 required 1");
        end
        tick();
        cfg_apply = 1'b1;
        tick();
        cfg_apply = 1'b0;
        checks++;
        if (afe_word() !== cfg_b) begin
            errors++;
            $display("FAIL busy_write_ignored: afe=%b required %b", afe_word(), cfg_b);
        end
        $display("apply_midpulse: old=%b new=%b ignored=%b", cfg_a, cfg_b, cfg_c);
    endtask

    task automatic test_enable_abort();
        logic valid_seen;
        valid_seen = 1'b0;
        enable = 1'b1; hit_ready = 1'b1;
        afe_outdis = 1'b0;
        repeat (6) begin
            tick();
            valid_seen = valid_seen | hit_valid;
        end
        enable = 1'b0;
        repeat (4) begin
            tick();
            valid_seen = valid_seen | hit_valid;
        end
        afe_outdis = 1'b1;
        repeat (10) begin
            tick();
            valid_seen = valid_seen | hit_valid;
        end
        enable = 1'b1;
        checks++;
        if (valid_seen !== 1'b0 || drop_cnt !== 8'(exp_drop)) begin
            errors++;
            $display("FAIL enable_abort: valid_seen=%b drop=%0d required 0/%0d", valid_seen, drop_cnt, exp_drop);
        end
        $display("enable_abort: valid_seen=%b drop=%0d", valid_seen, drop_cnt);
    endtask

    task automatic test_drop_saturate();
        hit_ready = 1'b0;
        drive_pulse(1, 4);
        for (int k = 0; k < 256; k++) begin
            drive_pulse(1, 3);
            exp_drop = sat_drop(exp_drop + 1);
        end
        checks++;
        if (drop_cnt !== 8'(exp_drop) || hit_valid !== 1'b1 || int'(hit_tot) != exp_tot(1)) begin
            errors++;
            $display("FAIL drop_saturate: drop=%0d valid=%b tot=%0d required %0d/1/%0d",
                     drop_cnt, hit_valid, hit_tot, exp_drop, exp_tot(1));
        end
        $display("drop_saturate: drop=%0d", drop_cnt);
    endtask

    task automatic test_reset_mid_handshake();
        @(posedge clk);
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if (hit_valid !== 1'b0 || hit_tot !== '0 || drop_cnt !== 8'd0 ||
            afe_word() !== 10'd0 || cfg_busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b tot=%0d drop=%0d afe=%b busy=%b required all 0",
                     hit_valid, hit_tot, drop_cnt, afe_word(), cfg_busy);
        end
        tick();
        rst_b = 1'b1;
        exp_drop = 0;
        repeat (2) tick();
        checks++;
        if (hit_valid !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL post_reset: valid=%b drop=%0d required 0/0", hit_valid, drop_cnt);
        end
        $display("reset_mid_handshake: outputs cleared");
    endtask

    initial begin
        test_reset();
        test_cfg_idle();
        test_single_hit();
        test_saturate();
        test_random_pulses();
        test_back_to_back();
        test_apply_midpulse();
        test_enable_abort();
        test_drop_saturate();
        test_reset_mid_handshake();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
